// File: rtl/prof_pkg.sv
// rtl/prof_pkg.sv - shared types and constants for the ap_ctrl transaction profiler
package prof_pkg;

  localparam int DEF_CNT_W = 32;
  localparam int DEF_ID_W  = 16;
  localparam int DROP_W    = 16;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  // Record layout seen by the dump/readout stage at the default widths.
  typedef struct packed {
    logic [DEF_CNT_W-1:0] ts;
    logic [DEF_CNT_W-1:0] interval;
  } start_entry_t;

  typedef struct packed {
    logic [DEF_ID_W-1:0]  id;
    logic [DEF_CNT_W-1:0] latency;
    logic [DEF_CNT_W-1:0] interval;
  } rec_t;

endpackage

// File: rtl/prof_sync_fifo.sv
// rtl/prof_sync_fifo.sv - show-ahead synchronous FIFO, push allowed when full if popping
module prof_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ap_ctrl_profiler.sv
// rtl/ap_ctrl_profiler.sv - timestamps ap_ctrl_hs start/done pairs and streams latency/interval records
module ap_ctrl_profiler
  import prof_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int ID_W  = DEF_ID_W,
  parameter int DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ap_start,
  input  logic              ap_ready,
  input  logic              ap_done,
  input  logic              ap_continue,
  input  logic              finish,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [ID_W-1:0]   rec_id,
  output logic [CNT_W-1:0]  rec_latency,
  output logic [CNT_W-1:0]  rec_interval,
  output logic              drained,
  output logic              proto_err,
  output logic [DROP_W-1:0] drop_cnt
);

  state_t           state;
  logic [CNT_W-1:0] now;
  logic [CNT_W-1:0] last_start;
  logic             have_start;
  logic [ID_W-1:0]  id;

  logic [CNT_W-1:0] start_iv;
  logic             start_ok, done_ev;
  logic             pair_q, pair_now, paired;
  logic             sf_push, start_drop, start_take, orphan;
  logic             rf_push, rf_pop, rec_drop;

  logic             sf_full, sf_empty, rf_full, rf_empty;
  logic [2*CNT_W-1:0]      sf_rd;
  logic [CNT_W-1:0]        sf_ts, sf_iv;
  logic [ID_W+2*CNT_W-1:0] rf_wr, rf_rd;
  logic [CNT_W-1:0]        rec_lat_d, rec_iv_d;

  // New starts are only taken before finish; dones keep draining afterwards.
  assign start_ok = ap_start & ap_ready & ((state == IDLE) | (state == RUN)) & ~finish;
  assign done_ev  = ap_done & ap_continue;
  assign start_iv = have_start ? (now - last_start) : '0;

  assign {sf_ts, sf_iv} = sf_rd;

  // A done prefers the oldest queued start; a same-cycle start only pairs when nothing is queued.
  assign pair_q     = done_ev & ~sf_empty;
  assign pair_now   = done_ev & sf_empty & start_ok;
  assign paired     = pair_q | pair_now;
  assign orphan     = done_ev & sf_empty & ~start_ok;
  assign sf_push    = start_ok & ~pair_now & (~sf_full | pair_q);
  assign start_drop = start_ok & ~pair_now & sf_full & ~pair_q;
  assign start_take = pair_now | sf_push;

  assign rec_lat_d = pair_q ? (now - sf_ts) : '0;
  assign rec_iv_d  = pair_q ? sf_iv : start_iv;
  assign rf_wr     = {id, rec_lat_d, rec_iv_d};

  assign rec_valid = ~rf_empty;
  assign rf_pop    = rec_valid & rec_ready;
  assign rf_push   = paired & (~rf_full | rf_pop);
  assign rec_drop  = paired & rf_full & ~rf_pop;

  // Storage contents are undefined until written, so gate the fields while empty.
  assign rec_id       = rec_valid ? rf_rd[ID_W+2*CNT_W-1 -: ID_W] : '0;
  assign rec_latency  = rec_valid ? rf_rd[2*CNT_W-1 -: CNT_W] : '0;
  assign rec_interval = rec_valid ? rf_rd[CNT_W-1:0] : '0;

  prof_sync_fifo #(.W(2*CNT_W), .DEPTH(DEPTH)) u_start_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (sf_push),
    .push_data ({now, start_iv}),
    .pop       (pair_q),
    .pop_data  (sf_rd),
    .full      (sf_full),
    .empty     (sf_empty)
  );

  prof_sync_fifo #(.W(ID_W+2*CNT_W), .DEPTH(DEPTH)) u_rec_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (rf_push),
    .push_data (rf_wr),
    .pop       (rf_pop),
    .pop_data  (rf_rd),
    .full      (rf_full),
    .empty     (rf_empty)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      now        <= '0;
      last_start <= '0;
      have_start <= 1'b0;
      id         <= '0;
      drop_cnt   <= '0;
      proto_err  <= 1'b0;
      state      <= IDLE;
      drained    <= 1'b0;
    end else begin
      now <= now + CNT_W'(1);
      if (start_take) begin
        last_start <= now;
        have_start <= 1'b1;
      end
      if (paired) id <= id + ID_W'(1);
      if (rec_drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_W'(1);
      if (orphan || start_drop) proto_err <= 1'b1;
      case (state)
        IDLE: begin
          if (finish) begin
            state   <= DONE;
            drained <= 1'b1;
          end else if (start_ok) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (finish) state <= FLUSH;
        end
        FLUSH: begin
          if (sf_empty) begin
            state   <= DONE;
            drained <= 1'b1;
          end
        end
        default: begin
          state   <= DONE;
          drained <= 1'b1;
        end
      endcase
    end
  end

endmodule
